// File: rtl/approx_error_monitor.sv
// approx_error_monitor: accumulates error statistics of an approximate adder
// against its exact reference over a programmed number of samples.
// Input handshake -> stage 1 (signed difference) -> stage 2 (|diff| and stats).
module approx_error_monitor #(
    parameter int N     = 32,
    parameter int CNT_W = 16,
    parameter int ACC_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       approx_sum,
    input  logic [N:0]       exact_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N:0]       max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic             acc_ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               s1_valid_q, s1_valid_d;
    logic [N+1:0]       diff_q, diff_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [N:0]         max_ed_q, max_ed_d;
    logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
    logic               acc_ovf_q, acc_ovf_d;

    logic               clear;
    logic               accept;
    logic [N+1:0]       mag;
    logic [ACC_W:0]     ed_ext;
    logic [ACC_W:0]     sum_tot;

    // Ready only while the run still owes samples; independent of in_valid.
    assign in_ready = (state_q == RUN) && (acc_cnt_q < num_q);
    assign accept   = in_valid && in_ready;

    // Run-control FSM: start handling, accept counting, drain of stage 1.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        acc_cnt_d = acc_cnt_q;
        clear     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (start) begin
                    clear     = 1'b1;
                    num_d     = num_samples;
                    acc_cnt_d = '0;
                    state_d   = (num_samples == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (acc_cnt_d == num_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: sign-extended difference, one extra bit so it never overflows.
    always_comb begin
        s1_valid_d = accept;
        diff_d     = diff_q;
        if (accept) diff_d = {exact_sum[N], exact_sum} - {approx_sum[N], approx_sum};
    end

    // Stage 2: magnitude of the difference folded into the run statistics.
    // The top bit of mag is always zero; it is carried into the sum anyway.
    always_comb begin
        mag           = diff_q[N+1] ? ('0 - diff_q) : diff_q;
        ed_ext        = '0;
        ed_ext[N+1:0] = mag;
        sum_tot       = {1'b0, sum_ed_q} + ed_ext;
        sample_cnt_d  = sample_cnt_q;
        err_cnt_d     = err_cnt_q;
        max_ed_d      = max_ed_q;
        sum_ed_d      = sum_ed_q;
        acc_ovf_d     = acc_ovf_q;
        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            max_ed_d     = '0;
            sum_ed_d     = '0;
            acc_ovf_d    = 1'b0;
        end else if (s1_valid_q) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (mag != '0) err_cnt_d = err_cnt_q + 1'b1;
            if (mag[N:0] > max_ed_q) max_ed_d = mag[N:0];
            if (sum_tot[ACC_W]) begin
                sum_ed_d  = '1;
                acc_ovf_d = 1'b1;
            end else begin
                sum_ed_d  = sum_tot[ACC_W-1:0];
            end
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_q        <= '0;
            acc_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            diff_q       <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            max_ed_q     <= '0;
            sum_ed_q     <= '0;
            acc_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            acc_cnt_q    <= acc_cnt_d;
            s1_valid_q   <= s1_valid_d;
            diff_q       <= diff_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            max_ed_q     <= max_ed_d;
            sum_ed_q     <= sum_ed_d;
            acc_ovf_q    <= acc_ovf_d;
        end
    end

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign max_ed     = max_ed_q;
    assign sum_ed     = sum_ed_q;
    assign acc_ovf    = acc_ovf_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor (N=32, CNT_W=16, ACC_W=33 so saturation is reachable).
module tb_approx_error_monitor;

    localparam int N = 32, CNT_W = 16, ACC_W = 33;

    logic             clk = 1'b0;
    logic             rst_n, start, in_valid, in_ready, busy, done, acc_ovf;
    logic [CNT_W-1:0] num_samples, sample_cnt, err_cnt;
    logic [N:0]       approx_sum, exact_sum, max_ed;
    logic [ACC_W-1:0] sum_ed;

    approx_error_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .approx_sum(approx_sum),
        .exact_sum(exact_sum), .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [N:0] qa[$], qe[$];
    int acc_cyc[$];
    int done_cyc;
    longint e_cnt, e_err, e_max, e_sum;
    logic   e_ovf;
    logic [98:0] got, exp_v;

    function automatic longint sx(logic [N:0] x);
        return x[N] ? longint'(x) - (longint'(1) << (N + 1)) : longint'(x);
    endfunction

    // Reference: plain-arithmetic statistics over the first n queued samples.
    task automatic model(input int n);
        longint d, ed, maxacc;
        maxacc = (longint'(1) << ACC_W) - 1;
        e_cnt = 0; e_err = 0; e_max = 0; e_sum = 0; e_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            d  = sx(qe[i]) - sx(qa[i]);
            ed = (d < 0) ? -d : d;
            e_cnt++;
            if (ed != 0) e_err++;
            if (ed > e_max) e_max = ed;
            e_sum += ed;
            if (e_sum > maxacc) begin e_sum = maxacc; e_ovf = 1'b1; end
        end
        exp_v = {e_cnt[15:0], e_err[15:0], e_max[32:0], e_sum[32:0], e_ovf};
    endtask

    // Start a run now (caller sits just after a negedge) and feed the queue.
    task automatic run(input int n, input int gap_pct, input bit hold_valid);
        int idx = 0;
        int cyc = 0;
        acc_cyc.delete();
        done_cyc    = -1;
        num_samples = CNT_W'(n);
        start       = 1'b1;
        while (cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin done_cyc = cyc; break; end
            if (idx < qa.size() && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1; approx_sum = qa[idx]; exact_sum = qe[idx];
            end else if (hold_valid) begin
                in_valid = 1'b1; approx_sum = 33'($urandom); exact_sum = 33'($urandom) ^ 33'h1_0000_0000;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin idx++; acc_cyc.push_back(cyc); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        got = {in_ready, busy, done, acc_ovf, sample_cnt, err_cnt, max_ed, 28'(sum_ed)};
        tests++;
        if (got !== '0) begin fails++; $display("FAIL reset_state got %h exp 0", got); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        num_samples = 16'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; approx_sum = 33'(100 + i); exact_sum = 33'd7;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (sample_cnt !== 16'd2) begin fails++; $display("FAIL pre_reset_cnt got %0d exp 2", sample_cnt); end
        rst_n = 1'b0;
        #1;
        got = {in_ready, busy, done, acc_ovf, sample_cnt, err_cnt, max_ed, 28'(sum_ed)};
        tests++;
        if (got !== '0 || sum_ed !== '0) begin fails++; $display("FAIL async_reset got %h sum %h exp 0", got, sum_ed); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if ({done, busy} !== 2'b00) begin fails++; $display("FAIL post_reset_idle got done=%b busy=%b exp 0 0", done, busy); end
        end
    endtask

    task automatic test_exact();
        qa.delete(); qe.delete();
        for (int i = 0; i < 4; i++) begin qa.push_back(33'h0_A5A5A5A5); qe.push_back(33'h0_A5A5A5A5); end
        run(4, 0, 1'b0);
        got = {sample_cnt, err_cnt, max_ed, sum_ed, acc_ovf};
        exp_v = {16'd4, 16'd0, 33'd0, 33'd0, 1'b0};
        tests++;
        if (done_cyc < 0 || got !== exp_v) begin fails++; $display("FAIL exact_run done_cyc=%0d got %h exp %h", done_cyc, got, exp_v); end
    endtask

    task automatic test_signed();
        @(negedge clk);
        qa.delete(); qe.delete();
        qa.push_back(33'd100);          qe.push_back(33'd96);
        qa.push_back(33'h1_FFFF_FFFB);  qe.push_back(33'd3);
        run(2, 0, 1'b0);
        got = {sample_cnt, err_cnt, max_ed, sum_ed, acc_ovf};
        exp_v = {16'd2, 16'd2, 33'd8, 33'd12, 1'b0};
        tests++;
        if (done_cyc < 0 || got !== exp_v) begin fails++; $display("FAIL signed_err done_cyc=%0d got %h exp %h", done_cyc, got, exp_v); end
    endtask

    task automatic test_handshake();
        @(negedge clk);
        qa.delete(); qe.delete();
        for (int i = 0; i < 2; i++) begin qa.push_back(33'($urandom)); qe.push_back(33'($urandom)); end
        run(2, 0, 1'b1);
        tests++;
        if (acc_cyc.size() != 2) begin fails++; $display("FAIL hs_accepts got %0d exp 2", acc_cyc.size()); end
        else begin
            tests++;
            if (acc_cyc[0] != 1 || acc_cyc[1] != 2) begin fails++; $display("FAIL hs_consecutive got %0d,%0d exp 1,2", acc_cyc[0], acc_cyc[1]); end
            tests++;
            if (done_cyc != acc_cyc[1] + 3) begin fails++; $display("FAIL hs_done_latency got %0d exp %0d", done_cyc, acc_cyc[1] + 3); end
        end
        model(2);
        got = {sample_cnt, err_cnt, max_ed, sum_ed, acc_ovf};
        tests++;
        if (got !== exp_v) begin fails++; $display("FAIL hs_stats got %h exp %h", got, exp_v); end
        in_valid = 1'b1;
        @(negedge clk);
        tests++;
        if ({done, in_ready, busy} !== 3'b000) begin fails++; $display("FAIL hs_after_done got done=%b rdy=%b busy=%b exp 0 0 0", done, in_ready, busy); end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_restart();
        @(negedge clk);
        qa.delete(); qe.delete();
        run(0, 0, 1'b1);
        got = {sample_cnt, err_cnt, max_ed, sum_ed, acc_ovf};
        tests++;
        if (done_cyc != 2 || acc_cyc.size() != 0 || got !== '0) begin
            fails++; $display("FAIL zero_run done_cyc=%0d accepts=%0d got %h exp 2 0 0", done_cyc, acc_cyc.size(), got);
        end
        qa.push_back(33'd50); qe.push_back(33'd20);
        run(1, 0, 1'b0);
        got = {sample_cnt, err_cnt, max_ed, sum_ed, acc_ovf};
        exp_v = {16'd1, 16'd1, 33'd30, 33'd30, 1'b0};
        tests++;
        if (done_cyc < 0 || got !== exp_v) begin fails++; $display("FAIL restart_in_done done_cyc=%0d got %h exp %h", done_cyc, got, exp_v); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        qa.delete(); qe.delete();
        for (int i = 0; i < 2; i++) begin qa.push_back(33'h1_0000_0000); qe.push_back(33'h0_FFFF_FFFF); end
        run(2, 0, 1'b0);
        got = {sample_cnt, err_cnt, max_ed, sum_ed, acc_ovf};
        exp_v = {16'd2, 16'd2, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b1};
        tests++;
        if (done_cyc < 0 || got !== exp_v) begin fails++; $display("FAIL saturation done_cyc=%0d got %h exp %h", done_cyc, got, exp_v); end
    endtask

    // Random runs chained back-to-back, each started in the previous done cycle.
    task automatic test_random();
        int n;
        logic [N:0] a;
        @(negedge clk);
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(12, 1);
            qa.delete(); qe.delete();
            for (int i = 0; i < n; i++) begin
                a = 33'($urandom) ^ (33'($urandom_range(1)) << 32);
                qa.push_back(a);
                case ($urandom_range(2))
                    0: qe.push_back(a);
                    1: qe.push_back(a + 33'($urandom_range(16)) - 33'd8);
                    default: qe.push_back(33'($urandom) ^ (33'($urandom_range(1)) << 32));
                endcase
            end
            run(n, 30, 1'b0);
            model(n);
            got = {sample_cnt, err_cnt, max_ed, sum_ed, acc_ovf};
            tests++;
            if (done_cyc < 0 || got !== exp_v) begin fails++; $display("FAIL random_run%0d n=%0d done_cyc=%0d got %h exp %h", r, n, done_cyc, got, exp_v); end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; num_samples = '0;
        approx_sum = '0; exact_sum = '0;
        test_reset();
        test_exact();
        test_signed();
        test_handshake();
        test_zero_restart();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
